// File: rtl/fu_complete_arb.sv
// fu_complete_arb: holds one result per functional unit and broadcasts up to
// three of them per cycle on the CDB using a rotating-priority scan.
`ifndef XLEN
`define XLEN 32
`endif
module fu_complete_arb #(
    parameter int XLEN  = `XLEN,
    parameter int TAG_W = 6,
    parameter int NSRC  = 5,
    parameter int NCDB  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*TAG_W-1:0] src_tag,
    input  logic [NSRC*XLEN-1:0]  src_value,
    output logic [NSRC-1:0]       src_ready,
    output logic [NCDB-1:0]       cdb_valid,
    output logic [NCDB*TAG_W-1:0] cdb_tag,
    output logic [NCDB*XLEN-1:0]  cdb_value
);
    logic [NSRC-1:0]  hold_valid, grant;
    logic [TAG_W-1:0] hold_tag [NSRC];
    logic [XLEN-1:0]  hold_value [NSRC];
    logic [TAG_W-1:0] tag_a [NCDB];
    logic [XLEN-1:0]  value_a [NCDB];
    logic [2:0]       ptr, last, idx;
    logic [3:0]       sum;
    logic [1:0]       cnt;

    // Scan from ptr modulo 5; each grant takes the next free CDB port.
    always_comb begin
        grant = '0;
        cdb_valid = '0;
        cnt = '0;
        last = ptr;
        sum = '0;
        idx = '0;
        for (int p = 0; p < NCDB; p++) begin
            tag_a[p] = '0;
            value_a[p] = '0;
        end
        for (int k = 0; k < NSRC; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (!squash && hold_valid[idx] && cnt != 2'd3) begin
                grant[idx] = 1'b1;
                cdb_valid[cnt] = 1'b1;
                tag_a[cnt] = hold_tag[idx];
                value_a[cnt] = hold_value[idx];
                last = idx;
                cnt = cnt + 2'd1;
            end
        end
    end

    for (genvar p = 0; p < NCDB; p++) begin : g_pack
        assign cdb_tag[p*TAG_W +: TAG_W] = tag_a[p];
        assign cdb_value[p*XLEN +: XLEN] = value_a[p];
    end

    assign src_ready = squash ? '1 : (~hold_valid | grant);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_valid <= '0;
            ptr <= '0;
            for (int i = 0; i < NSRC; i++) begin
                hold_tag[i] <= '0;
                hold_value[i] <= '0;
            end
        end else if (squash) begin
            hold_valid <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_tag[i] <= src_tag[i*TAG_W +: TAG_W];
                    hold_value[i] <= src_value[i*XLEN +: XLEN];
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            if (|grant) ptr <= (last == 3'd4) ? 3'd0 : last + 3'd1;
        end
    end
endmodule

// File: tb/tb_fu_complete_arb.sv
// tb_fu_complete_arb: scoreboard bench; a reference model of the held results
// queues expected broadcasts and a negedge monitor pops and compares them.
module tb_fu_complete_arb;
    logic        clock, reset, squash;
    logic [4:0]  src_valid, src_ready;
    logic [29:0] src_tag;
    logic [159:0] src_value;
    logic [2:0]  cdb_valid;
    logic [17:0] cdb_tag;
    logic [95:0] cdb_value;

    fu_complete_arb #(.XLEN(32), .TAG_W(6)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .src_valid(src_valid), .src_tag(src_tag), .src_value(src_value),
        .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    typedef struct {int port; logic [5:0] tag; logic [31:0] val;} bc_t;
    bc_t        exp_q[$];
    logic [4:0] rdy_q[$];
    int         nvec = 0, nerr = 0;

    // reference model: the set of held results and the scan start point
    logic [4:0]  m_hv, m_rdy;
    logic [5:0]  m_tag [5];
    logic [31:0] m_val [5];
    int          m_ptr;
    logic [4:0]  cur_v;
    logic [5:0]  cur_t [5];
    logic [31:0] cur_d [5];
    logic        fair;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic offer(input int s, input logic [5:0] t, input logic [31:0] d);
        cur_v[s] = 1'b1;
        cur_t[s] = t;
        cur_d[s] = d;
    endtask

    task automatic gen(input int prob);
        for (int s = 0; s < 5; s++)
            if (!(cur_v[s] && !m_rdy[s])) begin
                cur_v[s] = ($urandom_range(0, 99) < prob);
                cur_t[s] = {3'($urandom), 3'(s)};
                cur_d[s] = $urandom;
            end
    endtask

    task automatic cycle(input logic sq, input logic rs);
        logic [4:0] g;
        int n, last, i;
        @(posedge clock);
        #1;
        reset = rs;
        squash = sq;
        src_valid = cur_v;
        for (int s = 0; s < 5; s++) begin
            src_tag[s*6 +: 6] = cur_t[s];
            src_value[s*32 +: 32] = cur_d[s];
        end
        g = '0;
        n = 0;
        last = 0;
        if (rs && !sq)
            for (int k = 0; k < 5; k++) begin
                i = (m_ptr + k) % 5;
                if (m_hv[i] && n < 3) begin
                    g[i] = 1'b1;
                    exp_q.push_back('{n, m_tag[i], m_val[i]});
                    n++;
                    last = i;
                end
            end
        m_rdy = (!rs || sq) ? 5'h1f : (~m_hv | g);
        rdy_q.push_back(m_rdy);
        if (!rs) begin
            m_hv = '0;
            m_ptr = 0;
        end else if (sq) begin
            m_hv = '0;
        end else begin
            for (int s = 0; s < 5; s++)
                if (cur_v[s] && m_rdy[s]) begin
                    m_hv[s] = 1'b1;
                    m_tag[s] = cur_t[s];
                    m_val[s] = cur_d[s];
                end else if (g[s]) m_hv[s] = 1'b0;
            if (n > 0) m_ptr = (last + 1) % 5;
        end
    endtask

    logic [4:0] seen_cur, seen_prev;
    int         fair_n = 0;
    always @(negedge clock) begin
        bc_t e;
        logic [4:0] r;
        seen_cur = '0;
        if (rdy_q.size() > 0) begin
            r = rdy_q.pop_front();
            chk("src_ready", 128'(src_ready), 128'(r));
        end
        for (int p = 0; p < 3; p++) begin
            if (cdb_valid[p]) begin
                seen_cur[cdb_tag[p*6 +: 3]] = 1'b1;
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL cdb_extra: port %0d tag %0h value %0h, none expected", p, cdb_tag[p*6 +: 6], cdb_value[p*32 +: 32]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.port != p || e.tag !== cdb_tag[p*6 +: 6] || e.val !== cdb_value[p*32 +: 32]) begin
                        nerr++;
                        $display("FAIL cdb_bcast: got port %0d tag %0h value %0h want port %0d tag %0h value %0h",
                                 p, cdb_tag[p*6 +: 6], cdb_value[p*32 +: 32], e.port, e.tag, e.val);
                    end
                end
            end else begin
                chk("cdb_unused_zero", 128'({cdb_tag[p*6 +: 6], cdb_value[p*32 +: 32]}), 128'(0));
            end
        end
        if (fair) begin
            if (fair_n >= 1) chk("fair_window", 128'(seen_cur | seen_prev), 128'(5'h1f));
            seen_prev = seen_cur;
            fair_n++;
        end else fair_n = 0;
    end

    initial begin
        reset = 0; squash = 0; src_valid = 0; src_tag = 0; src_value = 0;
        cur_v = 0; m_hv = 0; m_ptr = 0; m_rdy = '1; fair = 0;
        for (int s = 0; s < 5; s++) begin
            cur_t[s] = 0; cur_d[s] = 0; m_tag[s] = 0; m_val[s] = 0;
        end
        repeat (2) @(negedge clock);
        #1;
        chk("rst_cdb_valid", 128'(cdb_valid), 128'(0));
        chk("rst_ready", 128'(src_ready), 128'(5'h1f));
        chk("rst_tag_value", 128'({cdb_tag, cdb_value}), 128'(0));

        // all five offered with ptr=0
        for (int s = 0; s < 5; s++) offer(s, 6'(10 + s), 32'h100 + 32'(s));
        cycle(0, 1);
        cur_v = 0;
        cycle(0, 1);
        @(negedge clock); #1;
        chk("oversub_ready", 128'(src_ready), 128'(5'b00111));
        chk("oversub_valid", 128'(cdb_valid), 128'(3'b111));
        cycle(0, 1);
        @(negedge clock); #1;
        chk("oversub_second", 128'(cdb_valid), 128'(3'b011));
        cycle(0, 1);

        // single ALU0 result
        offer(0, 6'd5, 32'h1234);
        cycle(0, 1);
        cur_v = 0;
        cycle(0, 1);
        @(negedge clock); #1;
        chk("single_valid", 128'(cdb_valid), 128'(3'b001));
        chk("single_tag", 128'(cdb_tag[5:0]), 128'(5));
        chk("single_value", 128'(cdb_value[31:0]), 128'(32'h1234));
        cycle(0, 1);
        @(negedge clock); #1;
        chk("single_idle", 128'(cdb_valid), 128'(0));
        chk("single_ptr", 128'(dut.ptr), 128'(1));

        // back-pressure on mult while hold[3] waits behind 4,0,1
        offer(3, 6'd20, 32'h20);
        cycle(0, 1);
        cur_v = 0;
        cycle(0, 1);
        offer(4, 6'd24, 32'h24); offer(0, 6'd25, 32'h25); offer(1, 6'd26, 32'h26); offer(3, 6'd6, 32'h66);
        cycle(0, 1);
        cur_v = 0;
        offer(3, 6'd7, 32'h77);
        cycle(0, 1);
        @(negedge clock); #1;
        chk("bp_ready3", 128'(src_ready[3]), 128'(0));
        cycle(0, 1);
        cur_v = 0;
        cycle(0, 1);
        @(negedge clock); #1;
        chk("bp_valid", 128'(cdb_valid), 128'(3'b001));
        chk("bp_tag7", 128'(cdb_tag[5:0]), 128'(7));

        // squash with four held and mult offering tag 9
        offer(0, 6'd30, 32'h30); offer(1, 6'd31, 32'h31); offer(2, 6'd32, 32'h32); offer(4, 6'd34, 32'h34);
        cycle(0, 1);
        cur_v = 0;
        offer(3, 6'd9, 32'h99);
        cycle(1, 1);
        @(negedge clock); #1;
        chk("squash_valid", 128'(cdb_valid), 128'(0));
        chk("squash_ready", 128'(src_ready), 128'(5'h1f));
        cur_v = 0;
        cycle(0, 1);
        @(negedge clock); #1;
        chk("squash_hold", 128'(dut.hold_valid), 128'(0));
        chk("squash_after", 128'(cdb_valid), 128'(0));

        // asynchronous reset with four held
        for (int s = 0; s < 4; s++) offer(s, 6'(40 + s), 32'h400 + 32'(s));
        cycle(0, 1);
        cur_v = 0;
        cycle(0, 1);
        @(negedge clock); #2;
        reset = 0;
        #1;
        chk("amid_valid", 128'(cdb_valid), 128'(0));
        chk("amid_ready", 128'(src_ready), 128'(5'h1f));
        m_hv = 0; m_ptr = 0; m_rdy = '1;
        cycle(0, 0);
        offer(0, 6'd33, 32'hbeef);
        cycle(0, 1);
        cur_v = 0;
        cycle(0, 1);
        @(negedge clock); #1;
        chk("post_rst_valid", 128'(cdb_valid), 128'(3'b001));
        chk("post_rst_tag", 128'(cdb_tag[5:0]), 128'(33));

        // randomized traffic with occasional squash
        repeat (400) begin
            gen(60);
            cycle(1'($urandom_range(0, 19) == 0), 1);
        end
        cur_v = 0;
        repeat (4) cycle(0, 1);

        // all sources continuously valid
        for (int c = 0; c < 22; c++) begin
            gen(100);
            cycle(0, 1);
            if (c == 2) fair = 1;
        end
        fair = 0;
        cur_v = 0;
        repeat (4) cycle(0, 1);
        @(negedge clock); #1;
        chk("drain_empty", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
